param_shift_counter: RTL

PARAM_SHIFT_COUNTER -- requirements
Module: param_shift_counter

---
 rtl/shift_counter_pkg.sv | 35 +++
 rtl/shift_state_check.sv | 48 ++++
 rtl/param_shift_counter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/shift_counter_pkg.sv
// Shared definitions for the parameterised ring/Johnson shift counter:
// mode and direction encodings, the per-edge action type and the seed helper.
package shift_counter_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // What the counter does at a given clock edge, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_STEP    = 2'd1,
    ACT_CORRECT = 2'd2,
    ACT_LOAD    = 2'd3
  } action_e;

  // Seed state for a counter of the given width in the given mode.
  // Ring seeds with a single one in bit 0; Johnson seeds with all zeros.
  // Callers size the result down to their own width.
  function automatic logic [MAX_WIDTH-1:0] seed_of(input int unsigned width,
                                                   input logic        mode);
    logic [MAX_WIDTH-1:0] seed;
    if ((mode == MODE_RING) && (width != 32'd0)) begin
      seed = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      seed = {MAX_WIDTH{1'b0}};
    end
    return seed;
  endfunction

endpackage

// File: rtl/shift_state_check.sv
// Combinational legality checker: flags a counter state that is not one of
// the states the current mode can legitimately reach.
module shift_state_check
  import shift_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic             illegal
);

  logic [WIDTH-1:0] one_s;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH-1:0] inc_s;
  logic [WIDTH-1:0] inv_s;
  logic [WIDTH-1:0] inv_inc_s;
  logic             ring_ok_s;
  logic             low_run_s;
  logic             high_run_s;
  logic             johnson_ok_s;

  // Classify the state: one-hot for ring, a run of ones anchored at either end for Johnson.
  always_comb begin
    one_s     = {{(WIDTH-1){1'b0}}, 1'b1};
    dec_s     = state - one_s;
    inc_s     = state + one_s;
    inv_s     = ~state;
    inv_inc_s = inv_s + one_s;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    ring_ok_s = (state != {WIDTH{1'b0}}) && ((state & dec_s) == {WIDTH{1'b0}});

    // 0..01..1 (including all-zeros and all-ones): adding one carries out of every set bit.
    low_run_s  = ((state & inc_s) == {WIDTH{1'b0}});
    // 1..10..0: the complement is a low-anchored run.
    high_run_s = ((inv_s & inv_inc_s) == {WIDTH{1'b0}});

    johnson_ok_s = low_run_s || high_run_s;

    case (mode)
      MODE_RING:    illegal = ~ring_ok_s;
      MODE_JOHNSON: illegal = ~johnson_ok_s;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/param_shift_counter.sv
// Parameterised ring / Johnson shift counter with direction control,
// synchronous load, illegal-state correction and a wrap pulse.
module param_shift_counter
  import shift_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             illegal
);

  // The reset value of the counter is the seed of whatever mode is selected,
  // which is an input. Rather than an asynchronous load of a data-dependent
  // value, reset sets seeded_q and out presents the live seed until the first
  // clock edge, where the seed is captured into out_q.
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             seeded_q;
  logic             seeded_d;

  logic [WIDTH-1:0] seed_s;
  logic [WIDTH-1:0] cur_s;
  logic [WIDTH-1:0] step_s;
  logic             illegal_s;
  action_e          act_s;

  // Current visible state: live seed straight after reset, otherwise the register.
  always_comb begin
    seed_s = WIDTH'(seed_of(WIDTH, mode));
    if (seeded_q) begin
      cur_s = seed_s;
    end else begin
      cur_s = out_q;
    end
  end

  shift_state_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .state   (cur_s),
    .mode    (mode),
    .illegal (illegal_s)
  );

  // Normal step: rotate for ring, rotate with inverted feedback for Johnson.
  always_comb begin
    case ({mode, dir})
      {MODE_RING,    DIR_LEFT}:  step_s = {cur_s[WIDTH-2:0], cur_s[WIDTH-1]};
      {MODE_RING,    DIR_RIGHT}: step_s = {cur_s[0], cur_s[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_LEFT}:  step_s = {cur_s[WIDTH-2:0], ~cur_s[WIDTH-1]};
      {MODE_JOHNSON, DIR_RIGHT}: step_s = {~cur_s[0], cur_s[WIDTH-1:1]};
      default:                   step_s = cur_s;
    endcase
  end

  // Pick the edge action by priority: load, correction, step, hold.
  always_comb begin
    if (load) begin
      act_s = ACT_LOAD;
    end else if (en && illegal_s) begin
      act_s = ACT_CORRECT;
    end else if (en) begin
      act_s = ACT_STEP;
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next state and wrap pulse; wrap only follows a normal step that lands on the seed.
  always_comb begin
    out_d    = cur_s;
    wrap_d   = 1'b0;
    seeded_d = 1'b0;
    case (act_s)
      ACT_LOAD: begin
        out_d  = load_val;
        wrap_d = 1'b0;
      end
      ACT_CORRECT: begin
        out_d  = seed_s;
        wrap_d = 1'b0;
      end
      ACT_STEP: begin
        out_d  = step_s;
        wrap_d = (step_s == seed_s);
      end
      ACT_HOLD: begin
        out_d  = cur_s;
        wrap_d = 1'b0;
      end
      default: begin
        out_d  = cur_s;
        wrap_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= {WIDTH{1'b0}};
      wrap_q   <= 1'b0;
      seeded_q <= 1'b1;
    end else begin
      out_q    <= out_d;
      wrap_q   <= wrap_d;
      seeded_q <= seeded_d;
    end
  end

  assign out     = cur_s;
  assign wrap    = wrap_q;
  assign illegal = illegal_s;

endmodule
